// File: rtl/writereg_scoreboard.sv
// rtl/writereg_scoreboard.sv - destination-register mux feeding an in-order pending-writeback queue with hazard flags
module writereg_scoreboard #(
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16,
    parameter int RD_LSB = 11,
    parameter int RA_IDX = 31,
    parameter int SP_IDX = 29,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        sel,
    input  logic [REG_AW-1:0] rt,
    input  logic [IMM_W-1:0]  imm,
    input  logic              issue,
    output logic              issue_ready,
    input  logic              commit,
    output logic [REG_AW-1:0] dest_out,
    output logic              dest_valid,
    input  logic [REG_AW-1:0] q_rs,
    input  logic [REG_AW-1:0] q_rt,
    output logic              hazard_rs,
    output logic              hazard_rt,
    output logic [REG_AW-1:0] sel_dest,
    output logic              commit_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [REG_AW-1:0] LP_RA   = REG_AW'(RA_IDX);
    localparam logic [REG_AW-1:0] LP_SP   = REG_AW'(SP_IDX);
    localparam logic [CW-1:0]     LP_FULL = CW'(DEPTH);

    logic [REG_AW-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              r_commit_err;

    logic w_empty;
    logic w_full;
    logic w_do_commit;
    logic w_do_issue;
    logic w_haz_rs;
    logic w_haz_rt;
    logic w_unused_imm;

    // Only the rd slice of imm is consumed; fold the rest so it is not flagged as dead.
    assign w_unused_imm = ^imm;

    always_comb begin
        sel_dest = rt;
        case (sel)
            2'b00: sel_dest = rt;
            2'b01: sel_dest = imm[RD_LSB +: REG_AW];
            2'b10: sel_dest = LP_RA;
            2'b11: sel_dest = LP_SP;
            default: sel_dest = rt;
        endcase
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == LP_FULL);
    assign w_do_commit = commit && !w_empty;
    // A full queue still accepts an issue when the head retires in the same cycle.
    assign w_do_issue  = issue && (!w_full || w_do_commit);

    assign issue_ready = !w_full;
    assign dest_valid  = !w_empty;
    assign dest_out    = dest_valid ? r_mem[r_rd_ptr] : '0;
    assign commit_err  = r_commit_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_vld        <= '0;
            r_commit_err <= 1'b0;
        end else begin
            if (commit && w_empty) begin
                r_commit_err <= 1'b1;
            end
            if (w_do_commit) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            // Issue after commit: when full both pointers alias and the new entry must stay valid.
            if (w_do_issue) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            case ({w_do_issue, w_do_commit})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_issue) begin
            r_mem[r_wr_ptr] <= sel_dest;
        end
    end

    always_comb begin
        w_haz_rs = 1'b0;
        w_haz_rt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_mem[i] == q_rs)) w_haz_rs = 1'b1;
            if (r_vld[i] && (r_mem[i] == q_rt)) w_haz_rt = 1'b1;
        end
    end

    // Register $zero is never busy.
    assign hazard_rs = w_haz_rs && (q_rs != '0);
    assign hazard_rt = w_haz_rt && (q_rt != '0);

endmodule

// File: tb/tb_writereg_scoreboard.sv
// tb/tb_writereg_scoreboard.sv - scoreboard bench for writereg_scoreboard
module tb_writereg_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic [4:0] rt;
    logic [15:0] imm;
    logic       issue;
    logic       issue_ready;
    logic       commit;
    logic [4:0] dest_out;
    logic       dest_valid;
    logic [4:0] q_rs;
    logic [4:0] q_rt;
    logic       hazard_rs;
    logic       hazard_rt;
    logic [4:0] sel_dest;
    logic       commit_err;

    writereg_scoreboard dut (
        .clk(clk), .reset(reset), .sel(sel), .rt(rt), .imm(imm),
        .issue(issue), .issue_ready(issue_ready), .commit(commit),
        .dest_out(dest_out), .dest_valid(dest_valid),
        .q_rs(q_rs), .q_rt(q_rt), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
        .sel_dest(sel_dest), .commit_err(commit_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    which;
        int    exp;
    } chk_t;

    chk_t chk_q[$];
    int   sb_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam int S_SEL = 0, S_DOUT = 1, S_DVLD = 2, S_RDY = 3, S_HRS = 4, S_HRT = 5, S_ERR = 6;

    function automatic int sample(input int which);
        case (which)
            S_SEL:   return int'(sel_dest);
            S_DOUT:  return int'(dest_out);
            S_DVLD:  return int'(dest_valid);
            S_RDY:   return int'(issue_ready);
            S_HRS:   return int'(hazard_rs);
            S_HRT:   return int'(hazard_rt);
            default: return int'(commit_err);
        endcase
    endfunction

    task automatic expect_val(input string name, input int which, input int exp);
        chk_t c;
        c.name = name;
        c.which = which;
        c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: retire-order scoreboard plus queued directed observations.
    always @(negedge clk) begin
        if (!reset && commit && dest_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: dest_out=%0d retired with no expected entry", dest_out);
            end else begin
                int e;
                e = sb_q.pop_front();
                if (int'(dest_out) != e) begin
                    errors++;
                    $display("FAIL sb_retire: dest_out=%0d expected=%0d", dest_out, e);
                end
            end
        end
        while (chk_q.size() > 0) begin
            chk_t c;
            int   a;
            c = chk_q.pop_front();
            a = sample(c.which);
            checks++;
            if (a != c.exp) begin
                errors++;
                $display("FAIL %s: got=%0d expected=%0d", c.name, a, c.exp);
            end
        end
    end

    initial begin
        reset = 1'b1; sel = 2'b00; rt = 5'd0; imm = 16'h0000;
        issue = 1'b0; commit = 1'b0; q_rs = 5'd0; q_rt = 5'd0;
        tick(); tick();
        reset = 1'b0; q_rs = 5'd8; q_rt = 5'd15;
        expect_val("rst_dest_valid", S_DVLD, 0);
        expect_val("rst_issue_ready", S_RDY, 1);
        expect_val("rst_dest_out", S_DOUT, 0);
        expect_val("rst_hazard_rs", S_HRS, 0);
        expect_val("rst_hazard_rt", S_HRT, 0);
        expect_val("rst_commit_err", S_ERR, 0);
        tick();

        // Mux sweep
        rt = 5'd8; imm = 16'h7800;
        sel = 2'b00; expect_val("mux_rt", S_SEL, 8);  tick();
        sel = 2'b01; expect_val("mux_rd", S_SEL, 15); tick();
        sel = 2'b10; expect_val("mux_ra", S_SEL, 31); tick();
        sel = 2'b11; expect_val("mux_sp", S_SEL, 29); tick();

        // Two issues, hazards, in-order retire
        sel = 2'b01; issue = 1'b1; sb_q.push_back(15); tick();
        sel = 2'b00; sb_q.push_back(8); tick();
        issue = 1'b0; q_rs = 5'd15; q_rt = 5'd8;
        expect_val("two_dest_valid", S_DVLD, 1);
        expect_val("two_dest_out", S_DOUT, 15);
        expect_val("two_hazard_rs", S_HRS, 1);
        expect_val("two_hazard_rt", S_HRT, 1);
        tick();
        commit = 1'b1;
        expect_val("commit_cycle_hazard_rs", S_HRS, 1);
        tick();
        commit = 1'b0;
        expect_val("after_c1_dest_out", S_DOUT, 8);
        expect_val("after_c1_hazard_rs", S_HRS, 0);
        expect_val("after_c1_hazard_rt", S_HRT, 1);
        tick();
        commit = 1'b1; tick();
        commit = 1'b0;
        expect_val("after_c2_dest_valid", S_DVLD, 0);
        expect_val("after_c2_hazard_rt", S_HRT, 0);
        tick();

        // Fill, drop when full, issue+commit when full
        sel = 2'b00; issue = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            rt = 5'(i); sb_q.push_back(i); tick();
        end
        issue = 1'b0;
        expect_val("full_issue_ready", S_RDY, 0);
        expect_val("full_dest_out", S_DOUT, 1);
        tick();
        rt = 5'd5; issue = 1'b1; tick();
        issue = 1'b0;
        expect_val("drop_issue_ready", S_RDY, 0);
        expect_val("drop_dest_out", S_DOUT, 1);
        tick();
        rt = 5'd6; issue = 1'b1; commit = 1'b1; sb_q.push_back(6); tick();
        issue = 1'b0; commit = 1'b0;
        expect_val("swap_issue_ready", S_RDY, 0);
        expect_val("swap_dest_out", S_DOUT, 2);
        tick();
        commit = 1'b1; tick(); tick(); tick();
        commit = 1'b0;
        expect_val("swap_tail_dest_out", S_DOUT, 6);
        expect_val("swap_tail_dest_valid", S_DVLD, 1);
        tick();
        commit = 1'b1; tick();
        commit = 1'b0;
        expect_val("drained_dest_valid", S_DVLD, 0);
        tick();

        // Index 0 never hazards
        rt = 5'd0; issue = 1'b1; sb_q.push_back(0); tick();
        issue = 1'b0; q_rs = 5'd0;
        expect_val("zero_hazard_rs", S_HRS, 0);
        expect_val("zero_dest_valid", S_DVLD, 1);
        expect_val("zero_dest_out", S_DOUT, 0);
        tick();
        commit = 1'b1; tick();
        commit = 1'b0; tick();

        // Sticky commit error
        commit = 1'b1; tick();
        commit = 1'b0;
        expect_val("err_set", S_ERR, 1);
        tick();
        rt = 5'd9; issue = 1'b1; sb_q.push_back(9); tick();
        issue = 1'b0; commit = 1'b1; tick();
        commit = 1'b0;
        expect_val("err_sticky", S_ERR, 1);
        expect_val("err_traffic_empty", S_DVLD, 0);
        tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        expect_val("err_cleared", S_ERR, 0);
        tick();

        // Duplicate pending index
        sel = 2'b10; issue = 1'b1; sb_q.push_back(31); tick();
        sb_q.push_back(31); tick();
        issue = 1'b0; q_rt = 5'd31;
        expect_val("dup_hazard_both", S_HRT, 1);
        tick();
        commit = 1'b1; tick();
        commit = 1'b0;
        expect_val("dup_hazard_one_left", S_HRT, 1);
        tick();
        commit = 1'b1; tick();
        commit = 1'b0;
        expect_val("dup_hazard_clear", S_HRT, 0);
        tick();

        // Reset with three pending entries discards them
        issue = 1'b1;
        sel = 2'b11; tick();
        sel = 2'b01; tick();
        sel = 2'b00; rt = 5'd7; tick();
        issue = 1'b0; q_rs = 5'd29; q_rt = 5'd7;
        expect_val("pre_rst_hazard_rs", S_HRS, 1);
        expect_val("pre_rst_hazard_rt", S_HRT, 1);
        tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        expect_val("mid_rst_dest_valid", S_DVLD, 0);
        expect_val("mid_rst_issue_ready", S_RDY, 1);
        expect_val("mid_rst_hazard_rs", S_HRS, 0);
        expect_val("mid_rst_hazard_rt", S_HRT, 0);
        expect_val("mid_rst_dest_out", S_DOUT, 0);
        tick(); tick();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: remaining=%0d expected=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
